// File: rtl/uart_rx_block_assembler_if.sv
// uart_rx_block_assembler_if
//   Valid/ready block handshake between the UART block assembler and its
//   consumer.
//   blk_data  : assembled block, first received byte in the top 8 bits
//   blk_valid : blk_data holds an unconsumed block
//   blk_ready : consumer takes blk_data when blk_valid && blk_ready
//   master = producer (assembler), slave = consumer.
interface uart_rx_block_assembler_if #(
  parameter int BLK_W = 128
);
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic             blk_ready;

  modport master (output blk_data, output blk_valid, input  blk_ready);
  modport slave  (input  blk_data, input  blk_valid, output blk_ready);
endinterface

// File: rtl/uart_rx_block_assembler.sv
// uart_rx_block_assembler
//   UART receiver: deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is
//   defined) and packs bytes into BLK_W = 8*BYTES_PER_BLK bit blocks that
//   are offered on a valid/ready handshake.
// Ports
//   PCLK          : clock, rising edge
//   PRESETn       : asynchronous active-low reset
//   rx            : serial line, idle high, asynchronous to PCLK
//   blk           : block handshake (master side): blk_data/blk_valid/blk_ready
//   rx_byte       : last received byte
//   rx_byte_valid : one-cycle pulse when rx_byte updates
//   frame_err     : one-cycle pulse on a bad stop bit
//   overrun_err   : one-cycle pulse when a completed block is dropped
//   parity_err    : (UART_RX_PARITY_EN only) one-cycle pulse on bad even parity
// Optional feature macro: UART_RX_PARITY_EN
module uart_rx_block_assembler #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int BYTES_PER_BLK = 16
)(
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              rx,
  uart_rx_block_assembler_if.master         blk,
  output logic [7:0]                        rx_byte,
  output logic                              rx_byte_valid,
  output logic                              frame_err,
  output logic                              overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                              parity_err
`endif
);

  localparam int BLK_W = 8 * BYTES_PER_BLK;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IW    = (BYTES_PER_BLK > 1) ? $clog2(BYTES_PER_BLK) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_sync;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [IW-1:0]    r_idx;
  logic [BLK_W-1:0] r_buf;
  logic [BLK_W-1:0] r_blk_data;
  logic             r_blk_valid;
  logic [7:0]       r_rx_byte;
  logic             r_rx_byte_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_rx_s, w_tick, w_last, w_fire, w_commit;
  logic             w_load_half, w_load_full, w_shift, w_first, w_stop_smp, w_par_smp;
  logic [BLK_W-1:0] w_blk;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_cnt == '0);

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], rx};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (w_tick)  w_next = w_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP;
`else
      S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP:  if (w_tick)  w_next = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift     = 1'b0;
    w_first     = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      S_IDLE:  w_load_half = !w_rx_s;
      S_START: begin w_load_full = w_tick; w_first = w_tick; end
      S_DATA:  begin w_load_full = w_tick; w_shift = w_tick; end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin w_load_full = w_tick; w_par_smp = w_tick; end
`endif
      S_STOP:  w_stop_smp = w_tick;
      default: ;
    endcase
  end

  // Baud counter: half a bit to reach mid start bit, then whole bits.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn)         r_cnt <= '0;
    else if (w_load_half) r_cnt <= CW'(HALF - 1);
    else if (w_load_full) r_cnt <= CW'(CLKS_PER_BIT - 1);
    else if (!w_tick)     r_cnt <= r_cnt - 1'b1;

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_first) r_bit <= '0;
      else if (w_shift) r_bit <= r_bit + 1'b1;
      if (w_shift) r_shift <= {w_rx_s, r_shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
  logic r_par, r_parity_err, w_par_bad;
  assign w_par_bad = ^{r_shift, r_par};   // even parity over data + parity bit
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_smp) r_par <= w_rx_s;
      r_parity_err <= w_stop_smp && w_par_bad;
    end
  assign parity_err = r_parity_err;
  assign w_commit   = w_stop_smp && w_rx_s && !w_par_bad;
`else
  assign w_commit   = w_stop_smp && w_rx_s;
`endif

  // ---------------- block assembly ----------------
  assign w_last = (r_idx == IW'(BYTES_PER_BLK - 1));
  assign w_fire = w_commit && w_last;

  // Final byte goes to the lowest lane; offer the block with it merged in.
  always_comb begin
    w_blk      = r_buf;
    w_blk[7:0] = r_shift;
  end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < BYTES_PER_BLK; i++)
        if (r_idx == IW'(i)) r_buf[BLK_W-1-8*i -: 8] <= r_shift;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_rx_byte_valid <= w_commit;
      r_frame_err     <= w_stop_smp && !w_rx_s;
      if (w_commit) r_rx_byte <= r_shift;
    end

  // Output register: a new block replaces the old only if the old one is
  // gone or leaving this cycle; otherwise the new one is dropped.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_blk_data  <= '0;
      r_blk_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_fire && r_blk_valid && !blk.blk_ready;
      if (w_fire && (!r_blk_valid || blk.blk_ready)) begin
        r_blk_data  <= w_blk;
        r_blk_valid <= 1'b1;
      end else if (r_blk_valid && blk.blk_ready) begin
        r_blk_valid <= 1'b0;
      end
    end

  assign blk.blk_data  = r_blk_data;
  assign blk.blk_valid = r_blk_valid;
  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign frame_err     = r_frame_err;
  assign overrun_err   = r_overrun;

endmodule
